dsp_t1_cfg_params: RTL and testbench
====================================

DSP_T1_CFG_PARAMS -- requirements
Module: dsp_t1_cfg_params

Interface
REQ-001 Parameter SHIFT_RIGHT, 6'd0, accumulator right-shift amount (0..63) applied on the output path.
REQ-002 Parameter REGISTER_INPUTS, 1'b0, 1 = all data/control inputs pass through one input register stage.
REQ-003 Parameter OUTPUT_SELECT, 3'h0, output source and registering (see REQ-021..023).
REQ-004 Parameter ROUND, 1'b0, 1 = round-half-up before the right shift.
REQ-005 Parameter SATURATE_ENABLE, 1'b0, 1 = saturate the shifted result to 38 bits.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 a_i  in  20  multiplicand A.
REQ-009 b_i  in  18  multiplicand B.
REQ-010 acc_fir_i  in  6  left-shift amount for the A preload path (feedback_i=2).
REQ-011 unsigned_a_i / unsigned_b_i  in  1 each  1 = operand is unsigned, 0 = two's complement.
REQ-012 feedback_i  in  3  accumulator mode select.
REQ-013 load_acc_i  in  1  1 = accumulator updates this cycle, 0 = accumulator holds.
REQ-014 subtract_i  in  1  1 = product is subtracted instead of added.
REQ-015 z_o  out  38  result.

Function
REQ-016 Product P = A x B as a 38-bit value; each operand is sign- or zero-extended per its unsigned_* bit.
REQ-017 P is extended to 64 bits: signed unless both unsigned_a_i and unsigned_b_i are 1; same rule sets the accumulator signedness for shift and saturate.
REQ-018 ACC is a 64-bit register; on each clk edge with load_acc_i=1: feedback_i=0 -> ACC <= ACC +/- P; feedback_i=1 -> ACC <= 0 +/- P; feedback_i=2 -> ACC <= (ext(A) << acc_fir_i) +/- P; feedback_i=3..7 -> same as 1.
REQ-019 ACC arithmetic is modulo 2^64; no internal saturation.
REQ-020 Post-processing of ACC: if ROUND=1 and SHIFT_RIGHT>0, add 2^(SHIFT_RIGHT-1); then arithmetic (signed) or logical (unsigned) right shift by SHIFT_RIGHT.
REQ-021 If SATURATE_ENABLE=1, clamp the shifted value to [-2^37, 2^37-1] when signed or [0, 2^38-1] when unsigned; otherwise truncate to bits [37:0].
REQ-022 OUTPUT_SELECT[1:0]: 0 -> z_o = P (combinational); 1 or 3 -> z_o = post-processed ACC; 2 -> z_o = ACC[37:0] raw.
REQ-023 OUTPUT_SELECT[2]=0 -> z_o combinational from the selected source (ACC paths reflect the current register value, zero cycles after the update edge); =1 -> z_o registered, one extra cycle of latency.
REQ-024 REGISTER_INPUTS=1 delays a_i, b_i, acc_fir_i, unsigned_*, feedback_i, load_acc_i, subtract_i by exactly one cycle; REGISTER_INPUTS=0 uses them directly.
REQ-025 Simultaneous accumulate and read: z_o (OUTPUT_SELECT=1, unregistered) shows the pre-edge ACC until the edge, then the new value.

Reset
REQ-026 rst=1 at a clk edge clears ACC, input registers and output register to 0; rst has priority over load_acc_i and feedback_i.
REQ-027 After reset with zero inputs, z_o = 0 for every OUTPUT_SELECT; reset mid-accumulation discards the partial sum.

Verification
REQ-028 FIR: SHIFT_RIGHT=10, ROUND=1, SATURATE_ENABLE=1, OUTPUT_SELECT=1, REGISTER_INPUTS=0, signed; after rst, 4 cycles feedback_i=0 with b=0x00400 and a=11,14,14,15 -> z_o=0x36; 5th cycle a=b=0, feedback_i=1 -> ACC cleared, z_o=0.
REQ-029 Repeat REQ-028 with b=0x00800 -> z_o=0x6C; with b=0 across a window -> z_o=0.
REQ-030 Rounding: SHIFT_RIGHT=10, single load a=1, b=512: ROUND=1 -> z_o=1; ROUND=0 -> z_o=0.
REQ-031 Saturation: SHIFT_RIGHT=0, OUTPUT_SELECT=1, repeated accumulate a=0x7FFFF, b=0x1FFFF until ACC > 2^37-1 -> z_o=0x1FFFFFFFFF; SATURATE_ENABLE=0 -> z_o=ACC[37:0].
REQ-032 OUTPUT_SELECT=0, signed a=-3, b=5 -> z_o=0x3FFFFFFFF1 same cycle; unsigned a=0xFFFFF, b=1 -> z_o=0xFFFFF.
REQ-033 REGISTER_INPUTS=1 or OUTPUT_SELECT[2]=1: each adds exactly one cycle to the REQ-028 result timing; rst asserted mid-window -> z_o=0 after the reset edge.

Source files
------------

// File: rtl/dsp_t1_cfg_params_if.sv
// Operand, control and result bundle for the configurable DSP multiply-accumulate.
// The master drives the operands and controls; the slave (the DSP) returns z_o.
interface dsp_t1_cfg_params_if;
  logic [19:0] a_i;
  logic [17:0] b_i;
  logic [5:0]  acc_fir_i;
  logic        unsigned_a_i;
  logic        unsigned_b_i;
  logic [2:0]  feedback_i;
  logic        load_acc_i;
  logic        subtract_i;
  logic [37:0] z_o;

  modport master (
    output a_i, b_i, acc_fir_i, unsigned_a_i, unsigned_b_i,
    output feedback_i, load_acc_i, subtract_i,
    input  z_o
  );

  modport slave (
    input  a_i, b_i, acc_fir_i, unsigned_a_i, unsigned_b_i,
    input  feedback_i, load_acc_i, subtract_i,
    output z_o
  );
endinterface

// File: rtl/dsp_t1_cfg_params.sv
// 20x18 multiplier with a 64-bit accumulator, a rounding/shifting/saturating output path
// and parameter-selected input and output register stages.
module dsp_t1_cfg_params #(
  parameter logic [5:0] SHIFT_RIGHT     = 6'd0,
  parameter logic       REGISTER_INPUTS = 1'b0,
  parameter logic [2:0] OUTPUT_SELECT   = 3'h0,
  parameter logic       ROUND           = 1'b0,
  parameter logic       SATURATE_ENABLE = 1'b0
) (
  input logic                      clk,
  input logic                      rst,
  dsp_t1_cfg_params_if.slave       bus
);

  typedef struct packed {
    logic [19:0] a;
    logic [17:0] b;
    logic [5:0]  acc_fir;
    logic        unsigned_a;
    logic        unsigned_b;
    logic [2:0]  feedback;
    logic        load_acc;
    logic        subtract;
  } in_t;

  in_t in_raw;
  in_t in_eff;

  assign in_raw = '{
    a:          bus.a_i,
    b:          bus.b_i,
    acc_fir:    bus.acc_fir_i,
    unsigned_a: bus.unsigned_a_i,
    unsigned_b: bus.unsigned_b_i,
    feedback:   bus.feedback_i,
    load_acc:   bus.load_acc_i,
    subtract:   bus.subtract_i
  };

  generate
    if (REGISTER_INPUTS) begin : g_in_reg
      in_t in_d;
      in_t in_q;

      always_comb begin
        in_d = in_raw;
      end

      always_ff @(posedge clk) begin
        if (rst) in_q <= '0;
        else     in_q <= in_d;
      end

      assign in_eff = in_q;
    end else begin : g_in_comb
      assign in_eff = in_raw;
    end
  endgenerate

  logic [37:0] a_ext;
  logic [37:0] b_ext;
  logic [37:0] prod;
  logic [63:0] prod64;
  logic [63:0] a64;
  logic        acc_signed;

  // Operands are widened to the product width so one unsigned multiply covers all sign modes.
  always_comb begin
    a_ext      = in_eff.unsigned_a ? {18'b0, in_eff.a} : {{18{in_eff.a[19]}}, in_eff.a};
    b_ext      = in_eff.unsigned_b ? {20'b0, in_eff.b} : {{20{in_eff.b[17]}}, in_eff.b};
    prod       = a_ext * b_ext;
    acc_signed = !(in_eff.unsigned_a && in_eff.unsigned_b);
    prod64     = acc_signed ? {{26{prod[37]}}, prod} : {26'b0, prod};
    a64        = in_eff.unsigned_a ? {44'b0, in_eff.a} : {{44{in_eff.a[19]}}, in_eff.a};
  end

  logic [63:0] acc_d;
  logic [63:0] acc_q;
  logic [63:0] acc_base;

  always_comb begin
    case (in_eff.feedback)
      3'd0:    acc_base = acc_q;
      3'd2:    acc_base = a64 << in_eff.acc_fir;
      default: acc_base = '0;
    endcase
    acc_d = acc_q;
    if (in_eff.load_acc) begin
      acc_d = in_eff.subtract ? (acc_base - prod64) : (acc_base + prod64);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  logic [63:0] rounded;
  logic [63:0] shifted;
  logic [37:0] clamped;
  logic [37:0] post;
  logic        fits;

  always_comb begin
    rounded = acc_q;
    if (ROUND && (SHIFT_RIGHT != 6'd0)) begin
      rounded = acc_q + (64'd1 << (SHIFT_RIGHT - 6'd1));
    end
    if (acc_signed) shifted = $signed(rounded) >>> SHIFT_RIGHT;
    else            shifted = rounded >> SHIFT_RIGHT;

    // A value fits when every bit above the 38-bit window matches the window's sign (or is zero).
    if (acc_signed) begin
      fits    = (shifted[63:37] == {27{shifted[63]}});
      clamped = shifted[63] ? {1'b1, 37'b0} : {1'b0, {37{1'b1}}};
    end else begin
      fits    = (shifted[63:38] == 26'b0);
      clamped = {38{1'b1}};
    end

    post = shifted[37:0];
    if (SATURATE_ENABLE && !fits) post = clamped;
  end

  logic [37:0] z_sel;

  always_comb begin
    case (OUTPUT_SELECT[1:0])
      2'd0:    z_sel = prod;
      2'd2:    z_sel = acc_q[37:0];
      default: z_sel = post;
    endcase
  end

  generate
    if (OUTPUT_SELECT[2]) begin : g_out_reg
      logic [37:0] z_d;
      logic [37:0] z_q;

      always_comb begin
        z_d = z_sel;
      end

      always_ff @(posedge clk) begin
        if (rst) z_q <= '0;
        else     z_q <= z_d;
      end

      assign bus.z_o = z_q;
    end else begin : g_out_comb
      assign bus.z_o = z_sel;
    end
  endgenerate

endmodule

// File: tb/tb_dsp_t1_cfg_params.sv
// Directed bench: eight differently configured DSP instances share one stimulus stream,
// each scenario checks the instances that exercise its feature.
module tb_dsp_t1_cfg_params;

  logic        clk;
  logic        rst;
  logic [19:0] a;
  logic [17:0] b;
  logic [5:0]  acc_fir;
  logic        ua;
  logic        ub;
  logic [2:0]  fb;
  logic        ld;
  logic        sub;
  logic [37:0] z [8];

  int compared   = 0;
  int mismatched = 0;

  // 0 fir, 1 round-off, 2 saturate, 3 no-saturate, 4 product, 5 input-reg, 6 output-reg, 7 raw acc
  dsp_t1_cfg_params_if bus_if [8] ();

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bus
      assign bus_if[gi].a_i          = a;
      assign bus_if[gi].b_i          = b;
      assign bus_if[gi].acc_fir_i    = acc_fir;
      assign bus_if[gi].unsigned_a_i = ua;
      assign bus_if[gi].unsigned_b_i = ub;
      assign bus_if[gi].feedback_i   = fb;
      assign bus_if[gi].load_acc_i   = ld;
      assign bus_if[gi].subtract_i   = sub;
      assign z[gi]                   = bus_if[gi].z_o;
    end
  endgenerate

  dsp_t1_cfg_params #(.SHIFT_RIGHT(6'd10), .REGISTER_INPUTS(1'b0), .OUTPUT_SELECT(3'h1),
                      .ROUND(1'b1), .SATURATE_ENABLE(1'b1))
    u_fir (.clk(clk), .rst(rst), .bus(bus_if[0]));
  dsp_t1_cfg_params #(.SHIFT_RIGHT(6'd10), .REGISTER_INPUTS(1'b0), .OUTPUT_SELECT(3'h1),
                      .ROUND(1'b0), .SATURATE_ENABLE(1'b1))
    u_rnd0 (.clk(clk), .rst(rst), .bus(bus_if[1]));
  dsp_t1_cfg_params #(.SHIFT_RIGHT(6'd0), .REGISTER_INPUTS(1'b0), .OUTPUT_SELECT(3'h1),
                      .ROUND(1'b0), .SATURATE_ENABLE(1'b1))
    u_sat (.clk(clk), .rst(rst), .bus(bus_if[2]));
  dsp_t1_cfg_params #(.SHIFT_RIGHT(6'd0), .REGISTER_INPUTS(1'b0), .OUTPUT_SELECT(3'h1),
                      .ROUND(1'b0), .SATURATE_ENABLE(1'b0))
    u_nosat (.clk(clk), .rst(rst), .bus(bus_if[3]));
  dsp_t1_cfg_params #(.SHIFT_RIGHT(6'd0), .REGISTER_INPUTS(1'b0), .OUTPUT_SELECT(3'h0),
                      .ROUND(1'b0), .SATURATE_ENABLE(1'b0))
    u_prod (.clk(clk), .rst(rst), .bus(bus_if[4]));
  dsp_t1_cfg_params #(.SHIFT_RIGHT(6'd10), .REGISTER_INPUTS(1'b1), .OUTPUT_SELECT(3'h1),
                      .ROUND(1'b1), .SATURATE_ENABLE(1'b1))
    u_ri (.clk(clk), .rst(rst), .bus(bus_if[5]));
  dsp_t1_cfg_params #(.SHIFT_RIGHT(6'd10), .REGISTER_INPUTS(1'b0), .OUTPUT_SELECT(3'h5),
                      .ROUND(1'b1), .SATURATE_ENABLE(1'b1))
    u_oreg (.clk(clk), .rst(rst), .bus(bus_if[6]));
  dsp_t1_cfg_params #(.SHIFT_RIGHT(6'd0), .REGISTER_INPUTS(1'b0), .OUTPUT_SELECT(3'h2),
                      .ROUND(1'b0), .SATURATE_ENABLE(1'b0))
    u_raw (.clk(clk), .rst(rst), .bus(bus_if[7]));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [19:0] av, input logic [17:0] bv,
                       input logic [2:0] fbv, input logic ldv, input logic subv);
    a   = av;
    b   = bv;
    fb  = fbv;
    ld  = ldv;
    sub = subv;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(20'h0, 18'h0, 3'd0, 1'b0, 1'b0);
    acc_fir = 6'd0;
    ua      = 1'b0;
    ub      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (z[i] !== 38'h0) begin
        mismatched++;
        $display("FAIL reset_z[%0d] got=%h want=%h", i, z[i], 38'h0);
      end else $display("ok   reset_z[%0d] z=%h", i, z[i]);
    end
  endtask

  task automatic test_fir(input logic [17:0] bv, input logic [37:0] exp, input string tag);
    logic [19:0] taps [4];
    taps = '{20'd11, 20'd14, 20'd14, 20'd15};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(taps[i], bv, 3'd0, 1'b1, 1'b0);
      tick();
    end
    compared++;
    if (z[0] !== exp) begin
      mismatched++;
      $display("FAIL %s_sum got=%h want=%h", tag, z[0], exp);
    end else $display("ok   %s_sum z=%h", tag, z[0]);

    drive(20'd0, 18'd0, 3'd1, 1'b1, 1'b0);
    tick();
    compared++;
    if (z[0] !== 38'h0) begin
      mismatched++;
      $display("FAIL %s_clear got=%h want=%h", tag, z[0], 38'h0);
    end else $display("ok   %s_clear z=%h", tag, z[0]);
    compared++;
    if (z[5] !== exp) begin
      mismatched++;
      $display("FAIL %s_inreg_late got=%h want=%h", tag, z[5], exp);
    end else $display("ok   %s_inreg_late z=%h", tag, z[5]);
    compared++;
    if (z[6] !== exp) begin
      mismatched++;
      $display("FAIL %s_outreg_late got=%h want=%h", tag, z[6], exp);
    end else $display("ok   %s_outreg_late z=%h", tag, z[6]);

    tick();
    compared++;
    if (z[5] !== 38'h0) begin
      mismatched++;
      $display("FAIL %s_inreg_clear got=%h want=%h", tag, z[5], 38'h0);
    end else $display("ok   %s_inreg_clear z=%h", tag, z[5]);
    compared++;
    if (z[6] !== 38'h0) begin
      mismatched++;
      $display("FAIL %s_outreg_clear got=%h want=%h", tag, z[6], 38'h0);
    end else $display("ok   %s_outreg_clear z=%h", tag, z[6]);
  endtask

  task automatic test_round();
    apply_reset();
    drive(20'd1, 18'd512, 3'd1, 1'b1, 1'b0);
    tick();
    compared++;
    if (z[0] !== 38'h1) begin
      mismatched++;
      $display("FAIL round_on got=%h want=%h", z[0], 38'h1);
    end else $display("ok   round_on z=%h", z[0]);
    compared++;
    if (z[1] !== 38'h0) begin
      mismatched++;
      $display("FAIL round_off got=%h want=%h", z[1], 38'h0);
    end else $display("ok   round_off z=%h", z[1]);
  endtask

  task automatic test_saturate();
    apply_reset();
    drive(20'h7FFFF, 18'h1FFFF, 3'd1, 1'b1, 1'b0);
    tick();
    drive(20'h7FFFF, 18'h1FFFF, 3'd0, 1'b1, 1'b0);
    tick();
    compared++;
    if (z[2] !== 38'h1FFFEC0002) begin
      mismatched++;
      $display("FAIL sat_below got=%h want=%h", z[2], 38'h1FFFEC0002);
    end else $display("ok   sat_below z=%h", z[2]);
    tick();
    compared++;
    if (z[2] !== 38'h1FFFFFFFFF) begin
      mismatched++;
      $display("FAIL sat_clamp got=%h want=%h", z[2], 38'h1FFFFFFFFF);
    end else $display("ok   sat_clamp z=%h", z[2]);
    compared++;
    if (z[3] !== 38'h2FFFE20003) begin
      mismatched++;
      $display("FAIL sat_off_wrap got=%h want=%h", z[3], 38'h2FFFE20003);
    end else $display("ok   sat_off_wrap z=%h", z[3]);
  endtask

  task automatic test_product();
    apply_reset();
    drive(20'hFFFFD, 18'd5, 3'd0, 1'b0, 1'b0);
    #1;
    compared++;
    if (z[4] !== 38'h3FFFFFFFF1) begin
      mismatched++;
      $display("FAIL prod_signed got=%h want=%h", z[4], 38'h3FFFFFFFF1);
    end else $display("ok   prod_signed z=%h", z[4]);
    ua = 1'b1;
    ub = 1'b1;
    drive(20'hFFFFF, 18'd1, 3'd0, 1'b0, 1'b0);
    #1;
    compared++;
    if (z[4] !== 38'h00000FFFFF) begin
      mismatched++;
      $display("FAIL prod_unsigned got=%h want=%h", z[4], 38'h00000FFFFF);
    end else $display("ok   prod_unsigned z=%h", z[4]);
    ub = 1'b0;
    drive(20'hFFFFF, 18'h3FFFF, 3'd0, 1'b0, 1'b0);
    #1;
    compared++;
    if (z[4] !== 38'h3FFFF00001) begin
      mismatched++;
      $display("FAIL prod_mixed got=%h want=%h", z[4], 38'h3FFFF00001);
    end else $display("ok   prod_mixed z=%h", z[4]);
    ua = 1'b0;
  endtask

  task automatic test_preload();
    apply_reset();
    acc_fir = 6'd4;
    drive(20'd3, 18'd0, 3'd2, 1'b1, 1'b0);
    tick();
    compared++;
    if (z[7] !== 38'd48) begin
      mismatched++;
      $display("FAIL preload_shift got=%h want=%h", z[7], 38'd48);
    end else $display("ok   preload_shift z=%h", z[7]);
    drive(20'd3, 18'd2, 3'd2, 1'b1, 1'b1);
    tick();
    compared++;
    if (z[7] !== 38'd42) begin
      mismatched++;
      $display("FAIL preload_sub got=%h want=%h", z[7], 38'd42);
    end else $display("ok   preload_sub z=%h", z[7]);
    acc_fir = 6'd0;
    drive(20'd9, 18'd9, 3'd1, 1'b0, 1'b0);
    tick();
    compared++;
    if (z[7] !== 38'd42) begin
      mismatched++;
      $display("FAIL hold got=%h want=%h", z[7], 38'd42);
    end else $display("ok   hold z=%h", z[7]);
    drive(20'd1, 18'd1, 3'd1, 1'b1, 1'b1);
    tick();
    compared++;
    if (z[7] !== 38'h3FFFFFFFFF) begin
      mismatched++;
      $display("FAIL sub_negative got=%h want=%h", z[7], 38'h3FFFFFFFFF);
    end else $display("ok   sub_negative z=%h", z[7]);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(20'd11, 18'h400, 3'd0, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(20'd11, 18'h400, 3'd0, 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) begin
      compared++;
      if (z[i] !== 38'h0) begin
        mismatched++;
        $display("FAIL midrst_z[%0d] got=%h want=%h", i, z[i], 38'h0);
      end else $display("ok   midrst_z[%0d] z=%h", i, z[i]);
    end
    compared++;
    if (z[0] !== 38'h0) begin
      mismatched++;
      $display("FAIL midrst_fir got=%h want=%h", z[0], 38'h0);
    end else $display("ok   midrst_fir z=%h", z[0]);
    tick();
    compared++;
    if (z[7] !== 38'h0) begin
      mismatched++;
      $display("FAIL midrst_hold got=%h want=%h", z[7], 38'h0);
    end else $display("ok   midrst_hold z=%h", z[7]);
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    acc_fir = 6'd0;
    ua      = 1'b0;
    ub      = 1'b0;
    drive(20'h0, 18'h0, 3'd0, 1'b0, 1'b0);

    test_reset();
    test_fir(18'h00400, 38'h36, "fir_b400");
    test_fir(18'h00800, 38'h6C, "fir_b800");
    test_fir(18'h00000, 38'h00, "fir_b0");
    test_round();
    test_saturate();
    test_product();
    test_preload();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
